// File: rtl/lif_readout_if.sv
// Beat stream carrying one lattice snapshot from lif_readout to its consumer.
interface lif_readout_if;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/lif_readout.sv
// Snapshots NCELLS lattice cells and streams them one 4-bit beat per cell, cell 0 first.
// Define LIF_READOUT_POP_EN to append a trailer beat holding the saturated popcount of the snapshot.
module lif_readout #(
  parameter int NCELLS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*NCELLS-1:0]   cells_i,
  input  logic                  snap_i,
  lif_readout_if.master         stream,
  output logic                  busy,
  output logic                  overrun
);

  localparam int IDXW = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCELLS - 1);

`ifdef LIF_READOUT_POP_EN
  typedef enum logic [1:0] {IDLE, SEND, TRAIL} state_t;
`else
  typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

  state_t                state;
  logic [IDXW-1:0]       idx;
  logic [IDXW-1:0]       idx_next;
  logic [4*NCELLS-1:0]   shadow;
  logic                  transfer;

  assign idx_next = idx + IDXW'(1);
  assign transfer = stream.out_valid & stream.out_ready;
  assign busy     = (state != IDLE);

`ifdef LIF_READOUT_POP_EN
  logic [3:0] trailer;

  // Counts every set bit of a snapshot, clamped to what one beat can carry.
  function automatic logic [3:0] sat_popcount(input logic [4*NCELLS-1:0] v);
    int count;
    count = 0;
    for (int i = 0; i < 4*NCELLS; i++) begin
      if (v[i]) count++;
    end
    return (count > 15) ? 4'hF : count[3:0];
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      idx              <= '0;
      shadow           <= '0;
      stream.out_data  <= '0;
      stream.out_valid <= 1'b0;
      stream.out_last  <= 1'b0;
      overrun          <= 1'b0;
`ifdef LIF_READOUT_POP_EN
      trailer          <= '0;
`endif
    end else begin
      overrun <= snap_i && (state != IDLE);

      case (state)
        IDLE: begin
          stream.out_valid <= 1'b0;
          stream.out_last  <= 1'b0;
          if (snap_i) begin
            shadow           <= cells_i;
            idx              <= '0;
            stream.out_data  <= cells_i[3:0];
            stream.out_valid <= 1'b1;
`ifdef LIF_READOUT_POP_EN
            trailer          <= sat_popcount(cells_i);
            stream.out_last  <= 1'b0;
`else
            stream.out_last  <= (NCELLS == 1);
`endif
            state            <= SEND;
          end
        end

        SEND: begin
          if (transfer) begin
            if (idx == LAST_IDX) begin
`ifdef LIF_READOUT_POP_EN
              stream.out_data  <= trailer;
              stream.out_last  <= 1'b1;
              state            <= TRAIL;
`else
              stream.out_data  <= '0;
              stream.out_valid <= 1'b0;
              stream.out_last  <= 1'b0;
              state            <= IDLE;
`endif
            end else begin
              // idx only advances on an accepted beat, so a stall holds data and last steady.
              idx             <= idx_next;
              stream.out_data <= shadow[{idx_next, 2'b00} +: 4];
`ifdef LIF_READOUT_POP_EN
              stream.out_last <= 1'b0;
`else
              stream.out_last <= (idx_next == LAST_IDX);
`endif
            end
          end
        end

`ifdef LIF_READOUT_POP_EN
        TRAIL: begin
          if (transfer) begin
            stream.out_data  <= '0;
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
            state            <= IDLE;
          end
        end
`endif

        default: begin
          state            <= IDLE;
          stream.out_valid <= 1'b0;
          stream.out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lif_readout.sv
// Randomized and directed bench for lif_readout against a frame-level queue model.
module tb_lif_readout;
  localparam int NCELLS = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                snap_i = 1'b0;
  logic [4*NCELLS-1:0] cells_i = '0;
  logic                busy;
  logic                overrun;

  lif_readout_if bus ();

  lif_readout #(.NCELLS(NCELLS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cells_i (cells_i),
    .snap_i  (snap_i),
    .stream  (bus),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       last;
  } beat_t;

  beat_t q[$];
  bit    active      = 1'b0;
  bit    exp_overrun = 1'b0;
  bit    just_reset  = 1'b0;
  int    checks      = 0;
  int    failures    = 0;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A frame is the ordered list of cell nibbles, plus the clamped popcount trailer when enabled.
  task automatic buildFrame(input logic [4*NCELLS-1:0] cells);
    beat_t b;
    int    pc;
    for (int k = 0; k < NCELLS; k++) begin
      b.data = cells[4*k +: 4];
`ifdef LIF_READOUT_POP_EN
      b.last = 1'b0;
`else
      b.last = (k == NCELLS - 1);
`endif
      q.push_back(b);
    end
`ifdef LIF_READOUT_POP_EN
    pc     = $countones(cells);
    b.data = (pc > 15) ? 4'hF : pc[3:0];
    b.last = 1'b1;
    q.push_back(b);
`endif
    pc = 0;
  endtask

  task automatic applyStimulus(input bit rst, input bit snap, input bit rdy,
                               input logic [4*NCELLS-1:0] cells);
    rst_n         = rst;
    snap_i        = snap;
    bus.out_ready = rdy;
    cells_i       = cells;

    if (!rst) begin
      q.delete();
      active      = 1'b0;
      exp_overrun = 1'b0;
      just_reset  = 1'b1;
    end else begin
      just_reset  = 1'b0;
      exp_overrun = snap && active;
      if (active) begin
        if (rdy) begin
          void'(q.pop_front());
          if (q.size() == 0) active = 1'b0;
        end
      end else if (snap) begin
        buildFrame(cells);
        active = 1'b1;
      end
    end

    @(posedge clk);
    #1;

    checkOutput("out_valid", 8'(bus.out_valid), 8'(active));
    checkOutput("busy", 8'(busy), 8'(active));
    checkOutput("overrun", 8'(overrun), 8'(exp_overrun));
    if (active) begin
      checkOutput("out_data", 8'(bus.out_data), 8'(q[0].data));
      checkOutput("out_last", 8'(bus.out_last), 8'(q[0].last));
    end else begin
      checkOutput("out_last_idle", 8'(bus.out_last), 8'h00);
      if (just_reset) checkOutput("out_data_reset", 8'(bus.out_data), 8'h00);
    end
  endtask

  initial begin
    bus.out_ready = 1'b0;

    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234);

    // Basic frame with a free-running consumer.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hA521);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b1, 16'hA521);

    // Consumer toggling ready 1,0,0,1,...
    applyStimulus(1'b1, 1'b1, 1'b0, 16'hA521);
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 1'b0, ((i % 3) == 0), 16'hA521);

    // Cells change right after capture and must not leak into the frame.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hA521);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFF);

    // Snapshot request held through a whole frame and beyond.
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b1, (i % 2) == 0, 16'h3C96 + 16'(i));
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000);

    // Reset during beat 2, then idle with no request.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hA521);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hA521);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hA521);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, 16'hA521);

    // All-ones snapshot exercises the saturated trailer.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFF);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, (i != 2), 16'hFFFF);

    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 59) != 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) != 0),
                    16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lif_readout.md
LIF_READOUT -- requirements
Module: lif_readout

Interface
REQ-001 Parameter NCELLS, default 4, number of lattice cells sampled per snapshot (range 1-16).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 cells_i  input  4*NCELLS  parallel cell states; cell k occupies bits [4k+3:4k]; bit order per cell {N,E,S,W} = {3,2,1,0}.
REQ-005 snap_i  input  1  snapshot request; sampled only in IDLE.
REQ-006 out_data  output  4  current beat payload.
REQ-007 out_valid  output  1  payload valid.
REQ-008 out_ready  input  1  downstream accept.
REQ-009 out_last  output  1  final beat of frame, qualified by out_valid.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 overrun  output  1  one-cycle pulse: snap_i rejected.

Function
REQ-012 FSM states IDLE, SEND, plus TRAIL when LIF_READOUT_POP_EN is defined.
REQ-013 IDLE with snap_i=1 at edge: capture cells_i into shadow register, idx<=0, go SEND; out_valid high the next cycle (1-cycle latency).
REQ-014 IDLE with snap_i=0: hold; out_valid=0, out_last=0.
REQ-015 SEND: out_valid=1, out_data=shadow[4*idx+3:4*idx]; cell 0 first.
REQ-016 Transfer = out_valid & out_ready at edge; only then idx increments.
REQ-017 out_valid & !out_ready: out_data, out_last, idx held stable; out_valid never deasserts before transfer.
REQ-018 Shadow register unchanged from capture until frame end; cells_i changes during frame have no effect.
REQ-019 Transfer with idx==NCELLS-1 in SEND ends cell beats: to IDLE (macro absent) or TRAIL (macro present).
REQ-020 idx width clog2(NCELLS), minimum 1; never wraps within a frame.
REQ-021 snap_i=1 while busy: ignored, overrun=1 for that cycle; frame unaffected.
REQ-022 snap_i=1 in the same cycle as the final transfer: overrun pulses; the FSM returns to IDLE; no new frame starts.
REQ-023 Back-to-back frames: earliest new capture is the cycle after return to IDLE.
REQ-024 All outputs registered or derived only from registered state; no combinational path from out_ready to out_valid.

Reset
REQ-025 rst_n=0 at edge: state IDLE, idx=0, shadow=0, out_valid=0, out_last=0, out_data=0, busy=0, overrun=0.
REQ-026 Reset mid-frame aborts the frame; no further beats of it are emitted after reset release.

Configuration
REQ-027 Macro LIF_READOUT_POP_EN: when defined, a popcount of all set bits in the shadow register is computed at capture; after the last cell beat the FSM enters TRAIL, emits one beat with out_data=min(popcount,15) and out_last=1, then returns to IDLE on transfer.
REQ-028 Without LIF_READOUT_POP_EN: no popcount logic, no TRAIL state; out_last=1 on the cell NCELLS-1 beat; frame length is exactly NCELLS beats.

Verification (NCELLS=4)
REQ-029 Reset then cells_i=16'hA521, snap_i pulse, out_ready=1 -> beats 1,2,5,A on consecutive cycles starting 1 cycle after snap; last on A (no macro) or extra beat 6 with last (macro).
REQ-030 Same frame, out_ready toggling 1,0,0,1,... -> every beat held stable while stalled; sequence and count identical to REQ-029.
REQ-031 cells_i changed to 16'hFFFF after capture -> emitted beats still 1,2,5,A.
REQ-032 snap_i held high across whole frame -> overrun high every busy cycle, exactly one frame emitted, next frame starts only after IDLE.
REQ-033 rst_n low during beat 2 -> next cycle all outputs 0, busy 0; after release no beats until new snap_i.
REQ-034 Macro defined, cells_i=16'hFFFF -> trailer beat out_data=4'hF (16 saturated), out_last=1.
